// File: rtl/bsg_circular_ptr_deq.sv
// Consumer-side read pointer and occupancy tracker for a slots_p-entry ring buffer.
// Define BSG_CIRCULAR_PTR_DEQ_PARTIAL_EN to grant partial dequeues instead of all-or-nothing.
module bsg_circular_ptr_deq #(
    parameter int unsigned slots_p   = 128,
    parameter int unsigned max_add_p = 10,
    localparam int unsigned ptr_w    = $clog2(slots_p),
    localparam int unsigned cnt_w    = $clog2(slots_p + 1),
    localparam int unsigned add_w    = $clog2(max_add_p + 1)
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [add_w-1:0] enq_cnt_i,
    input  logic             deq_v_i,
    input  logic [add_w-1:0] deq_cnt_i,
    output logic             deq_ready_o,
    output logic [add_w-1:0] deq_grant_o,
    output logic [ptr_w-1:0] o,
    output logic [ptr_w-1:0] n_o,
    output logic [cnt_w-1:0] count_o,
    output logic [cnt_w-1:0] free_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [ptr_w-1:0] ptr_q, ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic [cnt_w-1:0] deq_cnt_ext;
    logic             fits;
    logic [ptr_w:0]   ptr_sum;
    logic [cnt_w:0]   count_sum;

    assign deq_cnt_ext = cnt_w'(deq_cnt_i);
    assign fits        = (deq_cnt_ext <= count_q);

    // Grant depends on the registered count only; same-cycle enqueues are never bypassed.
    always_comb begin
        deq_ready_o = 1'b0;
        deq_grant_o = '0;
        if (!reset_i) begin
`ifdef BSG_CIRCULAR_PTR_DEQ_PARTIAL_EN
            deq_ready_o = (count_q != '0) || (deq_cnt_i == '0);
            if (deq_v_i) begin
                deq_grant_o = fits ? deq_cnt_i : count_q[add_w-1:0];
            end
`else
            deq_ready_o = fits;
            if (deq_v_i && fits) begin
                deq_grant_o = deq_cnt_i;
            end
`endif
        end
    end

    // Compare-subtract wrap keeps non-power-of-two depths correct.
    assign ptr_sum = {1'b0, ptr_q} + (ptr_w + 1)'(deq_grant_o);
    assign n_o     = (ptr_sum >= (ptr_w + 1)'(slots_p)) ?
                     ptr_w'(ptr_sum - (ptr_w + 1)'(slots_p)) : ptr_w'(ptr_sum);

    // grant <= count_q, so the sum never underflows; overflow means the producer overran.
    assign count_sum = {1'b0, count_q} + (cnt_w + 1)'(enq_cnt_i) - (cnt_w + 1)'(deq_grant_o);

    always_comb begin
        ptr_d   = n_o;
        count_d = count_sum[cnt_w-1:0];
        if (count_sum > (cnt_w + 1)'(slots_p)) begin
            count_d = cnt_w'(slots_p);
        end
        if (reset_i) begin
            ptr_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q   <= ptr_d;
        count_q <= count_d;
    end

    assign o       = ptr_q;
    assign count_o = count_q;
    assign free_o  = cnt_w'(slots_p) - count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == cnt_w'(slots_p));

endmodule

// File: tb/tb_bsg_circular_ptr_deq.sv
// Self-checking bench for bsg_circular_ptr_deq: vector table, corner sequences, random phase.
module tb_bsg_circular_ptr_deq;

    localparam int SLOTS = 128;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [3:0] enq_cnt_i;
    logic       deq_v_i;
    logic [3:0] deq_cnt_i;
    logic       deq_ready_o;
    logic [3:0] deq_grant_o;
    logic [6:0] o;
    logic [6:0] n_o;
    logic [7:0] count_o;
    logic [7:0] free_o;
    logic       empty_o;
    logic       full_o;

    always #5 clk = ~clk;

    bsg_circular_ptr_deq dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .enq_cnt_i   (enq_cnt_i),
        .deq_v_i     (deq_v_i),
        .deq_cnt_i   (deq_cnt_i),
        .deq_ready_o (deq_ready_o),
        .deq_grant_o (deq_grant_o),
        .o           (o),
        .n_o         (n_o),
        .count_o     (count_o),
        .free_o      (free_o),
        .empty_o     (empty_o),
        .full_o      (full_o)
    );

    typedef struct {
        int o;
        int cnt;
    } exp_t;

    typedef struct {
        int enq;
        int dv;
        int dc;
        int rdy;
        int g;
        int n;
        int o;
        int cnt;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[7];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_o     = 0;
    int   m_cnt   = 0;
    int   last_ready, last_grant, last_n;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_regs(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, sbq.size(), 1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        chk({tag, "_o"}, int'(o), e.o);
        chk({tag, "_count"}, int'(count_o), e.cnt);
        chk({tag, "_free"}, int'(free_o), SLOTS - e.cnt);
        chk({tag, "_empty"}, int'(empty_o), (e.cnt == 0) ? 1 : 0);
        chk({tag, "_full"}, int'(full_o), (e.cnt == SLOTS) ? 1 : 0);
    endtask

    // Drive one cycle, check combinational outputs against the model, then registered state.
    task automatic cycle(input int enq, input int dv, input int dc, input int rst,
                         input string tag);
        int g, rdy, nxt, c;
        @(negedge clk);
        reset_i   = rst[0];
        enq_cnt_i = enq[3:0];
        deq_v_i   = dv[0];
        deq_cnt_i = dc[3:0];
        if (rst != 0) begin
            rdy = 0;
            g   = 0;
        end else begin
`ifdef BSG_CIRCULAR_PTR_DEQ_PARTIAL_EN
            rdy = (m_cnt != 0 || dc == 0) ? 1 : 0;
            g   = (dv != 0) ? ((dc < m_cnt) ? dc : m_cnt) : 0;
`else
            rdy = (dc <= m_cnt) ? 1 : 0;
            g   = (dv != 0 && rdy != 0) ? dc : 0;
`endif
        end
        nxt = (m_o + g) % SLOTS;
        #1;
        last_ready = int'(deq_ready_o);
        last_grant = int'(deq_grant_o);
        last_n     = int'(n_o);
        chk({tag, "_ready"}, last_ready, rdy);
        chk({tag, "_grant"}, last_grant, g);
        chk({tag, "_n"}, last_n, nxt);
        if (rst != 0) begin
            m_o   = 0;
            m_cnt = 0;
        end else begin
            m_o = nxt;
            c   = m_cnt + enq - g;
            if (c > SLOTS) c = SLOTS;
            m_cnt = c;
        end
        sbq.push_back('{m_o, m_cnt});
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // enq, dv, dc, rdy, grant, n, o_after, cnt_after
        tbl[0] = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 0, 0, 0, 0, 0};
        tbl[2] = '{10, 0, 0, 1, 0, 0, 0, 10};
        tbl[3] = '{0, 1, 4, 1, 4, 4, 4, 6};
        tbl[4] = '{0, 1, 3, 1, 3, 7, 7, 3};
`ifdef BSG_CIRCULAR_PTR_DEQ_PARTIAL_EN
        tbl[5] = '{0, 1, 7, 1, 3, 10, 10, 0};
        tbl[6] = '{0, 1, 0, 1, 0, 10, 10, 0};
`else
        tbl[5] = '{0, 1, 7, 0, 0, 7, 7, 3};
        tbl[6] = '{0, 1, 0, 1, 0, 7, 7, 3};
`endif

        reset_i   = 1'b1;
        enq_cnt_i = '0;
        deq_v_i   = 1'b0;
        deq_cnt_i = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_o   = 0;
        m_cnt = 0;
        sbq.push_back('{0, 0});
        check_regs("reset");

        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].enq, tbl[i].dv, tbl[i].dc, 0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_ready", i), last_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_tbl_grant", i), last_grant, tbl[i].g);
            chk($sformatf("vec%0d_tbl_n", i), last_n, tbl[i].n);
            chk($sformatf("vec%0d_tbl_o", i), int'(o), tbl[i].o);
            chk($sformatf("vec%0d_tbl_count", i), int'(count_o), tbl[i].cnt);
        end

        // Walk the pointer up to 126, then dequeue across the wrap.
        for (int k = 0; k < 60 && m_o != 126; k++) begin
            int dc;
            dc = 126 - m_o;
            if (dc > 10) dc = 10;
            if (dc > m_cnt) dc = m_cnt;
            cycle(10, 1, dc, 0, "walk");
        end
        chk("wrap_reach_o", int'(o), 126);
        cycle(10, 0, 0, 0, "wrap_fill");
        cycle(0, 1, 5, 0, "wrap");
        chk("wrap_grant", last_grant, 5);
        chk("wrap_n", last_n, 3);
        chk("wrap_o", int'(o), 3);

        // Fill to full, then enqueue and dequeue together at full.
        cycle(0, 0, 0, 1, "rst_full");
        for (int k = 0; k < 12; k++) cycle(10, 0, 0, 0, "fill");
        cycle(8, 0, 0, 0, "fill_last");
        chk("full_count", int'(count_o), 128);
        chk("full_flag", int'(full_o), 1);
        chk("full_free", int'(free_o), 0);
        cycle(10, 1, 10, 0, "full_both");
        chk("full_both_grant", last_grant, 10);
        chk("full_both_count", int'(count_o), 128);
        chk("full_both_o", int'(o), 10);
        cycle(5, 0, 0, 0, "clamp");
        chk("clamp_count", int'(count_o), 128);
        chk("clamp_o", int'(o), 10);

        // Reset in the middle of operation with a live request.
        cycle(0, 0, 0, 1, "rst_mid_pre");
        for (int k = 0; k < 5; k++) cycle(10, 0, 0, 0, "to50");
        chk("mid_count50", int'(count_o), 50);
        cycle(0, 1, 5, 1, "rst_mid");
        chk("rst_mid_grant", last_grant, 0);
        chk("rst_mid_ready", last_ready, 0);
        chk("rst_mid_o", int'(o), 0);
        chk("rst_mid_count", int'(count_o), 0);

        // Legal random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            int room, enq;
            room = SLOTS - m_cnt;
            if (room > 10) room = 10;
            enq = $urandom_range(room, 0);
            cycle(enq, $urandom_range(1, 0), $urandom_range(10, 0),
                  ($urandom_range(63, 0) == 0) ? 1 : 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bsg_circular_ptr_deq.md
# bsg_circular_ptr_deq

Consumer-side companion to the producer circular pointer on a `slots_p`-entry ring buffer. It mirrors the producer's per-cycle add count to track occupancy, and it owns the read pointer. It arbitrates dequeue requests of up to `max_add_p` entries per cycle and exports free-slot credits back to the producer. It sits beside the ring storage, driving the read address, while the producer's pointer drives the write address.

## Interface
- `slots_p`, default 128: ring depth; any value ≥ `max_add_p`+1.
- `max_add_p`, default 10: maximum entries enqueued or dequeued per cycle.
- Derived widths:
  - `ptr_w` = clog2(`slots_p`), which is 7 at the defaults.
  - `cnt_w` = clog2(`slots_p`+1), which is 8.
  - `add_w` = clog2(`max_add_p`+1), which is 4.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset_i`  in  1  reset, synchronous and active-high.
- `enq_cnt_i`  in  `add_w`  entries the producer adds this cycle; identical to the producer pointer's add input.
- `deq_v_i`  in  1  dequeue request valid.
- `deq_cnt_i`  in  `add_w`  entries requested; range 0..`max_add_p`.
- `deq_ready_o`  out  1  request can be granted this cycle.
- `deq_grant_o`  out  `add_w`  entries actually dequeued this cycle.
- `o`  out  `ptr_w`  registered read pointer.
- `n_o`  out  `ptr_w`  next read pointer, equal to `o` + `deq_grant_o` with wrap.
- `count_o`  out  `cnt_w`  registered occupancy.
- `free_o`  out  `cnt_w`  `slots_p` − `count_o`; this is the producer's credit.
- `empty_o`  out  1  `count_o` == 0.
- `full_o`  out  1  `count_o` == `slots_p`.

## Operation
- State consists of two registers: read pointer `o` and occupancy `count_o`.
- Grant is computed combinationally from the current `count_o` only. Same-cycle enqueues are not bypassed.
- Dequeue rules, default build:
  - `deq_ready_o` = (`deq_cnt_i` ≤ `count_o`).
  - `deq_grant_o` = `deq_v_i` & `deq_ready_o` ? `deq_cnt_i` : 0.
  - An over-size request is refused whole.
- A request with `deq_v_i`=1 and `deq_cnt_i`=0 gives ready=1 and grant=0. It is legal and has no effect.
- Pointer update:
  - sum = `o` + grant.
  - `n_o` = sum ≥ `slots_p` ? sum − `slots_p` : sum.
  - The compare-subtract form is mandatory; a plain bit-width wrap is only correct when `slots_p` is a power of two.
- Occupancy update: `count_o` next = `count_o` + `enq_cnt_i` − grant.
  - `enq_cnt_i` > `free_o` is a producer protocol violation.
  - On a violation the next count clamps to `slots_p`.
  - Under the clamp the read pointer is unaffected.
- While `reset_i` is high:
  - `deq_ready_o`=0 and `deq_grant_o`=0.
  - `n_o`=`o`.
  - All inputs are ignored.

## Timing
- Reset values, one cycle after `reset_i` is sampled high: `o`=0, `count_o`=0, `free_o`=`slots_p`, `empty_o`=1, `full_o`=0.
- Reset mid-operation discards all occupancy. The producer must be reset in the same cycle.
- Entries enqueued in cycle t become grantable in cycle t+1.
- Grant is effective in the same cycle:
  - `n_o` and `deq_grant_o` are valid combinationally in cycle t.
  - `o` and `count_o` update at the end of cycle t.
- Credit loop: `free_o` reflects grants from cycle t in cycle t+1.
- Simultaneous enqueue and dequeue at full or empty are legal, provided each is legal against the registered count.
- No combinational path from `enq_cnt_i` to any output.

## Configuration
- Macro: `BSG_CIRCULAR_PTR_DEQ_PARTIAL_EN`.
- Defined (partial grants):
  - `deq_ready_o` = (`count_o` ≠ 0) | (`deq_cnt_i` == 0).
  - `deq_grant_o` = `deq_v_i` ? min(`deq_cnt_i`, `count_o`) : 0.
  - Over-size requests drain whatever is present.
- Undefined: the all-or-nothing rule from Operation applies.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle → `o`=0, `count_o`=0, `free_o`=128, `empty_o`=1, `deq_ready_o`=1 for `deq_cnt_i`=0 and 0 for `deq_cnt_i`=1.
- Enqueue 10, then next cycle request 4 → grant 4, `n_o`=4; following cycle `o`=4, `count_o`=6, `free_o`=122.
- Wrap: bring `o` to 126 with `count_o` ≥ 5, request 5 → grant 5, `n_o`=3, next `o`=3.
- Full: enqueue 10 per cycle for 12 cycles plus 8 → `count_o`=128, `full_o`=1, `free_o`=0. Then enqueue 10 while dequeuing 10 → `count_o` stays 128 and `o` advances 10.
- Over-request at `count_o`=3, request 7:
  - Default build: `deq_ready_o`=0, grant 0, state unchanged.
  - With `BSG_CIRCULAR_PTR_DEQ_PARTIAL_EN`: grant 3, next `count_o`=0, `empty_o`=1.
- Reset asserted with `count_o`=50 and `deq_v_i`=1, `deq_cnt_i`=5 → grant 0 during reset; next cycle `o`=0, `count_o`=0.
